// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and ID-stage opcode/funct constants for the pipeline controller.
// Contents:
//   state_t           - controller state (RUN, MD_WAIT, FROZEN)
//   OP_/FN_ constants - SPECIAL opcode and funct codes for mult/div and mfhi/mflo
//   is_muldiv()       - ID decode for id_is_muldiv
//   reads_hilo()      - ID decode for id_reads_hilo
package pipe_pkg;
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      FROZEN  = 2'd2
   } state_t;
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1a;
   localparam logic [5:0] FN_DIVU    = 6'h1b;
   function automatic logic is_muldiv(input logic [31:0] instr);
      return instr[31:26] == OP_SPECIAL && instr[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
   endfunction
   function automatic logic reads_hilo(input logic [31:0] instr);
      return instr[31:26] == OP_SPECIAL && instr[5:0] inside {FN_MFHI, FN_MFLO};
   endfunction
endpackage

// File: rtl/pipeline_ctrl_md_watchdog.sv
// md_watchdog: bounds how long a mult/div operation may stay outstanding.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - mult/div start pulse; restarts the count
//   busy        - mult/div outstanding; count advances while high
//   expire      - combinational; this busy cycle is the MD_TIMEOUT-th one
//   timeout     - sticky flag, set the cycle after expire, cleared only by reset
module md_watchdog #(
   parameter int MD_TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic busy,
   output logic expire,
   output logic timeout
);
   localparam int W = $clog2(MD_TIMEOUT + 1);
   logic [W-1:0] cnt;
   // cnt holds the number of busy cycles already completed, so the cycle that
   // would bring it to MD_TIMEOUT is the one that expires
   assign expire = busy && cnt == W'(MD_TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         if (start) cnt <= '0;
         else if (busy) cnt <= cnt + 1'b1;
         if (expire) timeout <= 1'b1;
      end
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   hazard_stall                    - RAW/load-use stall for the ID instruction
//   branch_taken                    - EX redirect this cycle
//   dmem_wait                       - data memory not ready, freeze the pipe
//   id_is_muldiv, id_reads_hilo     - ID decode of mult/div and mfhi/mflo
//   md_done                         - mult/div result written to HI/LO
//   pc_en, ifid_en, exmem_en, memwb_en - pipeline register load enables
//   ifid_flush, idex_bubble         - squash IF/ID, insert NOP into ID/EX
//   md_start, md_busy, md_timeout   - mult/div handshake and watchdog flag
//   stall_cycles                    - saturating count of cycles with pc_en=0
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hazard_stall,
   input  logic             branch_taken,
   input  logic             dmem_wait,
   input  logic             id_is_muldiv,
   input  logic             id_reads_hilo,
   input  logic             md_done,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             md_start,
   output logic             md_busy,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_cycles
);
   state_t state, shadow, mode;
   logic   md_expire, interlock, md_busy_n;
   // while frozen the pipe behaves as the state it will resume into
   assign mode = state == FROZEN ? shadow : state;
   // both mfhi/mflo and a second mult/div must wait for HI/LO to settle
   assign interlock = md_busy && (id_reads_hilo || id_is_muldiv);
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      md_start    = 1'b0;
      if (reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
      end else if (dmem_wait) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (interlock || hazard_stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         md_start = id_is_muldiv && mode == RUN;
      end
   end
   // md_done and watchdog expiry are honoured even while frozen
   assign md_busy_n = md_start ? 1'b1 : (md_done || md_expire) ? 1'b0 : md_busy;
   md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_wd (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .busy   (md_busy),
      .expire (md_expire),
      .timeout(md_timeout)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         shadow       <= RUN;
         md_busy      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         md_busy <= md_busy_n;
         shadow  <= md_busy_n ? MD_WAIT : RUN;
         state   <= dmem_wait ? FROZEN : md_busy_n ? MD_WAIT : RUN;
         if (!pc_en && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      end
   end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Merges four requests into one consistent set of per-stage enable, flush and bubble controls:
  - load-use and RAW stall from the hazard detector,
  - EX-stage branch/jump redirect,
  - the multi-cycle mult/div unit (HI/LO interlock),
  - data-memory wait.
- Owns the mult/div start handshake, a mult/div watchdog, and a stall-cycle performance counter.

Parameters:
- MD_TIMEOUT, 64: max cycles mult/div may stay busy before md_timeout is raised.
- CNT_W, 32: width of the stall_cycles counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- hazard_stall  in  1  RAW stall request from the hazard detector for the instruction in ID
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- dmem_wait  in  1  data memory not ready; MEM stage must hold
- id_is_muldiv  in  1  instruction in ID is mult/multu/div/divu
- id_reads_hilo  in  1  instruction in ID is mfhi/mflo
- md_done  in  1  mult/div unit result written to HI/LO (1-cycle pulse)
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX instead of ID output
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- md_start  out  1  1-cycle start pulse to the mult/div unit
- md_busy  out  1  mult/div operation outstanding
- md_timeout  out  1  sticky; watchdog expired
- stall_cycles  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- State register: RUN, MD_WAIT, FROZEN. Outputs are combinational from state and inputs; state, counters and flags are registered.
- Reset:
  - state=RUN, md_busy=0, md_timeout=0, stall_cycles=0.
  - Outputs during reset: pc_en=ifid_en=exmem_en=memwb_en=0, ifid_flush=1, idex_bubble=1, md_start=0.
  - Reset mid-operation abandons any mult/div in flight; md_done after reset is ignored.
- Priority, highest first: dmem_wait > branch_taken > HI/LO interlock > hazard_stall.
- dmem_wait=1 (any state):
  - All enables 0, no flush, no bubble; the whole pipe freezes.
  - md_start is suppressed.
  - Enter FROZEN; return to the prior state (RUN or MD_WAIT, held in a shadow register) the cycle after dmem_wait falls.
  - md_done is still accepted while frozen.
- branch_taken=1 (and no dmem_wait):
  - pc_en=1, ifid_flush=1, idex_bubble=1, exmem_en=memwb_en=1.
  - The hazard_stall for the squashed ID instruction is ignored.
  - A mult/div in ID is squashed: no md_start.
- HI/LO interlock:
  - Condition: id_reads_hilo=1 and md_busy=1.
  - pc_en=ifid_en=0, idex_bubble=1.
  - Holds every cycle until md_done. In the md_done cycle the stall remains; release occurs the next cycle.
- hazard_stall=1: pc_en=ifid_en=0, idex_bubble=1, exmem_en=memwb_en=1.
- Mult/div start:
  - md_start=1 in RUN when id_is_muldiv=1 and no higher-priority stall exists.
  - md_busy is set next cycle; state goes to MD_WAIT.
- Mult/div in MD_WAIT:
  - A second id_is_muldiv stalls ID exactly like the HI/LO interlock until md_done.
  - md_done clears md_busy and returns state to RUN.
  - md_done together with a new id_is_muldiv: a new start is issued the next cycle, not the same cycle.
- Watchdog:
  - The counter resets on md_start and increments while md_busy.
  - When the count reaches MD_TIMEOUT: md_timeout is set (sticky until reset), md_busy is forced to 0, and state goes to RUN.
- stall_cycles increments every non-reset cycle with pc_en=0 and saturates at all-ones.
- No stall state: all enables 1, flush=0, bubble=0.

Decomposition:
- Shared package pipe_pkg:
  - state encoding (RUN=2'd0, MD_WAIT=2'd1, FROZEN=2'd2),
  - the mult/div/mfhi/mflo opcode and funct constants used by the ID decode that drives id_is_muldiv and id_reads_hilo.
- One natural sub-module: md_watchdog (counter, compare, sticky flag).

Test Plan:
- Reset held 2 cycles, then released with no requests -> during reset pc_en=0, ifid_flush=1, idex_bubble=1; first post-reset cycle pc_en=ifid_en=exmem_en=memwb_en=1, stall_cycles=0.
- hazard_stall=1 for 2 cycles -> pc_en=0, idex_bubble=1 for exactly 2 cycles; stall_cycles=2.
- hazard_stall=1 and branch_taken=1 in the same cycle -> pc_en=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
- id_is_muldiv=1 in RUN, then id_reads_hilo=1 next cycle, md_done asserted 10 cycles after md_start -> md_start single pulse; pc_en=0 from the mfhi cycle through the md_done cycle; pc_en=1 the cycle after md_done.
- dmem_wait=1 for 3 cycles during MD_WAIT with md_done arriving in the middle -> all enables 0 for 3 cycles; state resumes in RUN; md_busy=0.
- md_start with no md_done, MD_TIMEOUT=8 -> md_timeout=1 after 8 busy cycles, md_busy=0; md_timeout stays 1 until reset.
